// File: rtl/vc_fifo.sv
// vc_fifo: per-virtual-channel word buffer behind demux_vcid.
// Registered read port, occupancy thresholds and a sticky error flag.
module vc_fifo #(
    parameter int DATA_WIDTH      = 6,
    parameter int DEPTH           = 8,
    parameter int ADDR_WIDTH      = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LP_AF    = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0]   LP_AE    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);
    localparam logic [ADDR_WIDTH:0]   LP_CNT1  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] LP_PTR1  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_error;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;
    logic w_bad;

    // Flags decode straight from the registered occupancy.
    assign w_full    = (r_count == LP_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_push_ok = push && !w_full;
    assign w_pop_ok  = pop && !w_empty;
    assign w_bad     = (push && w_full) || (pop && w_empty);

    // Storage array; stale words are harmless since count gates reads.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy, registered read port and sticky error.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR1;
            end
            if (w_pop_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + LP_PTR1;
            end
            r_valid_out <= w_pop_ok;
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + LP_CNT1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - LP_CNT1;
            end
            if (w_bad) begin
                r_error <= 1'b1;
            end
        end
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= LP_AF);
    assign almost_empty = (r_count <= LP_AE);
    assign fifo_count   = r_count;
    assign data_out     = r_data_out;
    assign valid_out    = r_valid_out;
    assign error        = r_error;

endmodule

// File: tb/tb_vc_fifo.sv
// tb_vc_fifo: directed self-checking bench for vc_fifo.
// Inputs change 1ns after the rising edge; outputs sampled there too.
module tb_vc_fifo;

    logic       clk;
    logic       reset_L;
    logic [5:0] data_in;
    logic       push;
    logic       pop;
    logic [5:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] fifo_count;
    logic       error;

    int n_cmp;
    int n_bad;

    vc_fifo dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .data_in      (data_in),
        .push         (push),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_count   (fifo_count),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic p, input logic q, input logic [5:0] d);
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_reset();
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        reset_L = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_L = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cnt"}, 32'(fifo_count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_ae"}, 32'(almost_empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_af"}, 32'(almost_full), 0);
        chk({tag, "_valid"}, 32'(valid_out), 0);
        chk({tag, "_err"}, 32'(error), 0);
        chk({tag, "_dout"}, 32'(data_out), 0);
    endtask

    logic [5:0] ord [4];
    logic [5:0] mix [7];

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset_L = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        #2;

        do_reset();
        chk_reset_state("rst");

        // Ordering
        ord = '{6'h11, 6'h32, 6'h33, 6'h14};
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, ord[i]);
        chk("ord_cnt4", 32'(fifo_count), 4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, '0);
            chk("ord_dout", 32'(data_out), 32'(ord[i]));
            chk("ord_valid", 32'(valid_out), 1);
        end
        step(1'b0, 1'b0, '0);
        chk("ord_valid_idle", 32'(valid_out), 0);
        chk("ord_empty", 32'(empty), 1);
        chk("ord_err", 32'(error), 0);

        // Thresholds and full
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 6'(8'h20 + i));
            chk("th_cnt", 32'(fifo_count), 32'(i + 1));
            chk("th_ae", 32'(almost_empty), (i + 1 <= 2) ? 1 : 0);
            chk("th_af", 32'(almost_full), (i + 1 >= 6) ? 1 : 0);
            chk("th_full", 32'(full), (i + 1 == 8) ? 1 : 0);
            chk("th_err", 32'(error), 0);
        end
        step(1'b1, 1'b0, 6'h3f);
        chk("ovf_err", 32'(error), 1);
        chk("ovf_cnt", 32'(fifo_count), 8);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, '0);
            chk("drain_dout", 32'(data_out), 32'(8'h20 + i));
            chk("drain_valid", 32'(valid_out), 1);
        end
        chk("drain_empty", 32'(empty), 1);

        // Underflow
        do_reset();
        chk("udf_pre_err", 32'(error), 0);
        step(1'b0, 1'b1, '0);
        chk("udf_valid", 32'(valid_out), 0);
        chk("udf_cnt", 32'(fifo_count), 0);
        chk("udf_err", 32'(error), 1);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 6'h07);
        chk("udf_sticky", 32'(error), 1);

        // Simultaneous push/pop
        do_reset();
        step(1'b1, 1'b0, 6'h01);
        step(1'b1, 1'b0, 6'h02);
        step(1'b1, 1'b0, 6'h03);
        step(1'b1, 1'b1, 6'h04);
        chk("pp3_cnt", 32'(fifo_count), 3);
        chk("pp3_dout", 32'(data_out), 32'h01);
        chk("pp3_valid", 32'(valid_out), 1);
        chk("pp3_err", 32'(error), 0);
        for (int i = 5; i <= 9; i++) step(1'b1, 1'b0, 6'(i));
        chk("pp8_pre_cnt", 32'(fifo_count), 8);
        step(1'b1, 1'b1, 6'h0a);
        chk("pp8_cnt", 32'(fifo_count), 7);
        chk("pp8_dout", 32'(data_out), 32'h02);
        chk("pp8_valid", 32'(valid_out), 1);
        chk("pp8_err", 32'(error), 1);
        mix = '{6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09};
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, '0);
            chk("pp8_drain", 32'(data_out), 32'(mix[i]));
        end
        chk("pp0_pre_empty", 32'(empty), 1);
        step(1'b1, 1'b1, 6'h15);
        chk("pp0_cnt", 32'(fifo_count), 1);
        chk("pp0_valid", 32'(valid_out), 0);
        chk("pp0_err", 32'(error), 1);
        step(1'b0, 1'b1, '0);
        chk("pp0_dout", 32'(data_out), 32'h15);
        chk("pp0_valid2", 32'(valid_out), 1);

        // Wrap-around
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, 6'(i));
            step(1'b0, 1'b1, '0);
            chk("wrap_dout", 32'(data_out), 32'(i));
            chk("wrap_valid", 32'(valid_out), 1);
        end
        chk("wrap_err", 32'(error), 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'(8'h30 + i));
        step(1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 6'h3a);
        chk("mid_cnt5", 32'(fifo_count), 5);
        chk("mid_valid_pre", 32'(valid_out), 0);
        chk("mid_dout_pre", 32'(data_out), 32'h30);
        step(1'b1, 1'b1, 6'h3b);
        chk("mid_valid_hi", 32'(valid_out), 1);
        #2;
        reset_L = 1'b0;
        #1;
        chk_reset_state("mid");
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        step(1'b1, 1'b0, 6'h2c);
        chk("post_cnt", 32'(fifo_count), 1);
        step(1'b0, 1'b1, '0);
        chk("post_dout", 32'(data_out), 32'h2c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
